data_mem_unit: RTL and testbench
================================

# data_mem_unit

Parametrised data memory for the CPU datapath, successor to the single-port memory file. One CPU request port with byte-enable writes, registered reads and a configurable read latency; a separate loader write port for testbench/boot image preload; and an optional post-reset clear sweep that zeroes the array before the CPU is allowed access. Sits between the MEM stage and the testbench loader.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 16, address width of both ports (word addresses)
- DEPTH, 1024, number of words implemented; DEPTH <= 2^ADDR_WIDTH
- READ_LATENCY, 1, cycles from accepted read to response; legal values 1 or 2
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset release; 0 = contents untouched

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all control/pipeline state, not the array
- cpu_req  in  1  request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_be  in  DATA_WIDTH/8  byte-lane write enables (ignored for reads)
- cpu_addr  in  ADDR_WIDTH  word address
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_ready  out  1  request accepted on an edge where cpu_req && cpu_ready
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata holds read response
- cpu_rdata  out  DATA_WIDTH  read data; holds last value when cpu_rvalid=0
- cpu_err  out  1  one-cycle pulse: response for an out-of-range access
- ld_we  in  1  loader write strobe (full word)
- ld_addr  in  ADDR_WIDTH  loader address
- ld_wdata  in  DATA_WIDTH  loader data
- init_busy  out  1  clear sweep in progress

## Operation
- States: INIT (clear sweep), RUN. Reset forces INIT if CLEAR_ON_RESET=1, else RUN; sweep counter -> 0.
- INIT: each edge writes 0 to mem[cnt], cnt++; after writing DEPTH-1 go to RUN. cpu_ready=0, init_busy=1, loader writes ignored.
- RUN: cpu_ready=1 every cycle; one request per cycle, back-to-back allowed, no stall.
- CPU write: lanes with cpu_be[i]=1 get cpu_wdata[8i+7:8i]; other lanes unchanged. cpu_be=0 is a legal no-op write.
- CPU read: full word, registered through READ_LATENCY stages; cpu_rvalid pulses once per accepted read.
- Out-of-range (cpu_addr >= DEPTH): write dropped; read returns 0. Either pulses cpu_err at read-response timing; cpu_rvalid also pulses for reads, never for writes.
- Loader: in RUN, ld_we writes ld_wdata to ld_addr; ld_addr >= DEPTH silently dropped, no err.
- Same-edge CPU write and loader write, same address: loader wins entirely. Different addresses: both commit.
- Same-edge CPU read and loader write, same address: read returns old data (read-first).
- Reset mid-operation: in-flight reads discarded (no rvalid after reset), sweep restarts from 0; array keeps prior contents until swept.

## Timing
- Reset values: cpu_ready = !CLEAR_ON_RESET, init_busy = CLEAR_ON_RESET, cpu_rvalid=0, cpu_err=0, cpu_rdata=0.
- Clear: with reset released before edge 1, edges 1..DEPTH write addresses 0..DEPTH-1; init_busy falls and cpu_ready rises after edge DEPTH.
- Read accepted at edge E: cpu_rvalid/cpu_rdata/cpu_err valid during the cycle after edge E+READ_LATENCY-1.
- Write accepted at edge E commits at E; read accepted at E+1 returns the new data.
- cpu_err for a write accepted at E uses the same timing as a read accepted at E.

## Test plan
- DEPTH=16, CLEAR_ON_RESET=1, array preloaded with 0xFFFFFFFF via loader in a prior run, pulse reset -> cpu_ready=0 for 16 edges, then every read returns 0x00000000.
- Write 0xAABBCCDD to addr 5 with cpu_be=4'b1111, then 0x11223344 with cpu_be=4'b0101 -> read of addr 5 returns 0xAA22CC44.
- READ_LATENCY=2, reads to addrs 0,1,2 on consecutive edges E,E+1,E+2 -> cpu_rvalid high for three consecutive cycles starting after E+1, data in request order.
- Same edge: CPU write 0x1 and loader write 0x2 to addr 3 -> addr 3 reads 0x2; CPU read and loader write to addr 4 (old 0x7, new 0x9) -> response 0x7, next read 0x9.
- Read and write to addr DEPTH (out of range) -> read returns 0 with cpu_err and cpu_rvalid; write produces cpu_err, no rvalid, addr 0 and DEPTH-1 unchanged.
- Assert reset one cycle after a read is accepted with READ_LATENCY=2 -> no cpu_rvalid pulse, all outputs at reset values, sweep restarts from address 0.

Source files
------------

// File: rtl/data_mem_unit.sv
// data_mem_unit: word-addressed data memory for the CPU datapath.
// One CPU request port (byte-enable writes, registered reads with 1 or 2
// cycles of latency), a full-word loader write port for image preload, and
// an optional post-reset sweep that zeroes the array before the CPU may use it.
module data_mem_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int DEPTH          = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [DATA_WIDTH/8-1:0] cpu_be,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  output logic                    cpu_ready,
  output logic                    cpu_rvalid,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    cpu_err,
  input  logic                    ld_we,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  input  logic [DATA_WIDTH-1:0]   ld_wdata,
  output logic                    init_busy
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  // Control state
  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_nxt;

  // Storage
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Request decode
  logic                  w_run;
  logic                  w_accept;
  logic                  w_cpu_in_range;
  logic                  w_ld_in_range;
  logic [IDX_W-1:0]      w_cpu_idx;
  logic [IDX_W-1:0]      w_ld_idx;
  logic                  w_sweep_wr;
  logic                  w_ld_wr;
  logic                  w_cpu_wr;
  logic                  w_rd_acc;
  logic                  w_err_acc;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // First response stage (captured on the accepting edge)
  logic                  r_s1_rvalid;
  logic                  r_s1_err;
  logic [DATA_WIDTH-1:0] r_s1_rdata;

  assign w_run     = (r_state == ST_RUN);
  assign cpu_ready = w_run;
  assign init_busy = (r_state == ST_INIT);

  assign w_cpu_in_range = ({1'b0, cpu_addr} < DEPTH_EXT);
  assign w_ld_in_range  = ({1'b0, ld_addr} < DEPTH_EXT);
  assign w_cpu_idx      = cpu_addr[IDX_W-1:0];
  assign w_ld_idx       = ld_addr[IDX_W-1:0];

  assign w_accept  = cpu_req && w_run;
  assign w_rd_acc  = w_accept && !cpu_we;
  assign w_err_acc = w_accept && !w_cpu_in_range;

  // Array writes are qualified with reset so nothing lands in the array while
  // reset is held; the array itself keeps its contents across reset.
  assign w_sweep_wr = reset && (r_state == ST_INIT);
  assign w_ld_wr    = reset && w_run && ld_we && w_ld_in_range;
  // A loader write to the same word takes the whole word, so the CPU write
  // is suppressed rather than merged.
  assign w_cpu_wr   = reset && w_accept && cpu_we && w_cpu_in_range &&
                      !(w_ld_wr && (ld_addr == cpu_addr));

  // Out-of-range reads return zero instead of whatever the index aliases to.
  assign w_rd_word = w_cpu_in_range ? r_mem[w_cpu_idx] : '0;

  // State and sweep-counter register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RESET_STATE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: the sweep advances one word per edge and hands over to
  // RUN right after the last word has been written.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = RESET_STATE;
    endcase
  end

  // Array write port: clear sweep, loader full-word write, CPU lane writes.
  // NOTE: the array has no reset branch; a reset on storage would turn it into
  // thousands of flops and prevent RAM inference. Clearing is done by the sweep.
  always_ff @(posedge clk) begin
    if (w_sweep_wr) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_cpu_wr) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (cpu_be[i]) begin
            r_mem[w_cpu_idx][8*i +: 8] <= cpu_wdata[8*i +: 8];
          end
        end
      end
      if (w_ld_wr) begin
        r_mem[w_ld_idx] <= ld_wdata;
      end
    end
  end

  // First read stage: samples the pre-edge word, which gives read-first
  // behaviour against a same-edge write to the same address. Data only moves
  // on an accepted read so the output holds between responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_rvalid <= 1'b0;
      r_s1_err    <= 1'b0;
      r_s1_rdata  <= '0;
    end else begin
      r_s1_rvalid <= w_rd_acc;
      r_s1_err    <= w_err_acc;
      if (w_rd_acc) begin
        r_s1_rdata <= w_rd_word;
      end
    end
  end

  generate
    if (READ_LATENCY >= 2) begin : g_lat2
      logic                  r_s2_rvalid;
      logic                  r_s2_err;
      logic [DATA_WIDTH-1:0] r_s2_rdata;

      // Second read stage: delays the response by one more cycle.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_s2_rvalid <= 1'b0;
          r_s2_err    <= 1'b0;
          r_s2_rdata  <= '0;
        end else begin
          r_s2_rvalid <= r_s1_rvalid;
          r_s2_err    <= r_s1_err;
          if (r_s1_rvalid) begin
            r_s2_rdata <= r_s1_rdata;
          end
        end
      end

      assign cpu_rvalid = r_s2_rvalid;
      assign cpu_err    = r_s2_err;
      assign cpu_rdata  = r_s2_rdata;
    end else begin : g_lat1
      assign cpu_rvalid = r_s1_rvalid;
      assign cpu_err    = r_s1_err;
      assign cpu_rdata  = r_s1_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: two instances (read latency 1 and 2, DEPTH 16,
// clear-on-reset) share one stimulus stream and are compared every cycle
// against a word-array reference model plus directed test-plan checks.
module tb_data_mem_unit;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req;
  logic          cpu_we;
  logic [3:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;

  logic          ready1, rvalid1, err1, busy1;
  logic [DW-1:0] rdata1;
  logic          ready2, rvalid2, err2, busy2;
  logic [DW-1:0] rdata2;

  always #5 clk = ~clk;

  data_mem_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) u_dut_l1 (
    .clk(clk), .reset(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(ready1), .cpu_rvalid(rvalid1), .cpu_rdata(rdata1), .cpu_err(err1),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .init_busy(busy1)
  );

  data_mem_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) u_dut_l2 (
    .clk(clk), .reset(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(ready2), .cpu_rvalid(rvalid2), .cpu_rdata(rdata2), .cpu_err(err2),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .init_busy(busy2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_init;
  int            m_cnt;
  // Response produced by edge n lives in slot n%4, tagged with n.
  int            r_edge [4];
  bit            r_rv   [4];
  bit            r_err  [4];
  logic [DW-1:0] r_data [4];
  logic [DW-1:0] held1, held2;

  function automatic void model_reset();
    m_init = 1'b1;
    m_cnt  = 0;
    for (int i = 0; i < 4; i++) r_edge[i] = -1;
    held1 = '0;
    held2 = '0;
  endfunction

  function automatic void model_edge();
    int            s;
    int            a;
    logic [DW-1:0] mask;
    cyc++;
    if (!rst_n) return;
    s         = cyc % 4;
    r_edge[s] = cyc;
    r_rv[s]   = 1'b0;
    r_err[s]  = 1'b0;
    r_data[s] = '0;
    if (m_init) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) m_init = 1'b0;
    end else begin
      a = int'(cpu_addr);
      if (cpu_req) begin
        r_err[s] = (a >= DEPTH);
        r_rv[s]  = !cpu_we;
        if (!cpu_we && a < DEPTH) r_data[s] = m_mem[a];
        if (cpu_we && a < DEPTH) begin
          mask = '0;
          for (int i = 0; i < 4; i++) if (cpu_be[i]) mask |= (32'hFF << (8 * i));
          m_mem[a] = (m_mem[a] & ~mask) | (cpu_wdata & mask);
        end
      end
      // Loader applied last: on a shared address it replaces the whole word.
      if (ld_we && int'(ld_addr) < DEPTH) m_mem[int'(ld_addr)] = ld_wdata;
    end
  endfunction

  task automatic compare_port(input int lat, input logic rv, input logic er,
                              input logic [DW-1:0] rd, inout logic [DW-1:0] held);
    int   e;
    int   s;
    logic exp_rv;
    logic exp_er;
    e      = cyc - lat + 1;
    exp_rv = 1'b0;
    exp_er = 1'b0;
    if (e >= 1) begin
      s = e % 4;
      if (r_edge[s] == e) begin
        exp_rv = r_rv[s];
        exp_er = r_err[s];
        if (r_rv[s]) held = r_data[s];
      end
    end
    check($sformatf("rvalid_l%0d", lat), {31'b0, rv}, {31'b0, exp_rv});
    check($sformatf("err_l%0d", lat),    {31'b0, er}, {31'b0, exp_er});
    check($sformatf("rdata_l%0d", lat),  rd, held);
  endtask

  task automatic compare_all();
    check("ready_l1", {31'b0, ready1}, {31'b0, !m_init});
    check("busy_l1",  {31'b0, busy1},  {31'b0, m_init});
    check("ready_l2", {31'b0, ready2}, {31'b0, !m_init});
    check("busy_l2",  {31'b0, busy2},  {31'b0, m_init});
    compare_port(1, rvalid1, err1, rdata1, held1);
    compare_port(2, rvalid2, err2, rdata2, held2);
  endtask

  // One clock: model sees the same inputs the DUT samples; outputs are
  // compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0; cpu_addr = '0; cpu_wdata = '0;
    ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},   {31'b0, ready1 | ready2},   32'd0);
    check({tag, "_busy"},    {31'b0, busy1 & busy2},     32'd1);
    check({tag, "_rvalid"},  {31'b0, rvalid1 | rvalid2}, 32'd0);
    check({tag, "_err"},     {31'b0, err1 | err2},       32'd0);
    check({tag, "_rdata1"},  rdata1, 32'd0);
    check({tag, "_rdata2"},  rdata2, 32'd0);
  endtask

  // Asynchronous reset pulse started from the falling edge; held two edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_vals("rst");
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < DEPTH - 1; i++) step();
    check({tag, "_busy_before_last"}, {31'b0, busy2}, 32'd1);
    step();
    check({tag, "_ready_after_sweep"}, {31'b0, ready1 & ready2}, 32'd1);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [3:0] be);
    idle(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(a); cpu_wdata = d; cpu_be = be;
    step(); idle();
  endtask

  task automatic ld(input int a, input logic [DW-1:0] d);
    idle(); ld_we = 1'b1; ld_addr = AW'(a); ld_wdata = d;
    step(); idle();
  endtask

  task automatic rd_expect(input string tag, input int a, input logic [DW-1:0] exp);
    idle(); cpu_req = 1'b1; cpu_addr = AW'(a);
    step(); idle();
    check({tag, "_l1"}, rdata1, exp);
    step();
    check({tag, "_l2"}, rdata2, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    sweep("sweep0");

    // Preload all ones, then reset: sweep must zero every word.
    for (int a = 0; a < DEPTH; a++) ld(a, 32'hFFFF_FFFF);
    ld(DEPTH, 32'h1234_5678);
    ld(16'hFFFF, 32'h1234_5678);
    rd_expect("preload", 7, 32'hFFFF_FFFF);
    pulse_reset();
    sweep("sweep1");
    for (int a = 0; a < DEPTH; a++) rd_expect($sformatf("cleared%0d", a), a, 32'h0);

    // Byte-enable merge.
    wr(5, 32'hAABB_CCDD, 4'b1111);
    wr(5, 32'h1122_3344, 4'b0101);
    rd_expect("be_merge", 5, 32'hAA22_CC44);
    wr(6, 32'hDEAD_BEEF, 4'b0000);
    rd_expect("be_none", 6, 32'h0);

    // Back-to-back reads 0,1,2.
    ld(0, 32'hA0); ld(1, 32'hA1); ld(2, 32'hA2);
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i < 3) begin cpu_req = 1'b1; cpu_addr = AW'(i); end
      step();
      if (i >= 1) begin
        check("b2b_rvalid_l2", {31'b0, rvalid2}, 32'd1);
        check("b2b_rdata_l2", rdata2, 32'hA0 + DW'(i - 1));
      end
    end
    idle();

    // Same-edge CPU write and loader write: loader wins.
    idle(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 3; cpu_wdata = 32'h1;
    ld_we = 1'b1; ld_addr = 3; ld_wdata = 32'h2;
    step(); idle();
    rd_expect("coll_wr", 3, 32'h2);
    // Same-edge CPU read and loader write: read-first.
    wr(4, 32'h7, 4'hF);
    idle(); cpu_req = 1'b1; cpu_addr = 4; ld_we = 1'b1; ld_addr = 4; ld_wdata = 32'h9;
    step(); idle();
    check("coll_rd_l1", rdata1, 32'h7);
    step();
    check("coll_rd_l2", rdata2, 32'h7);
    rd_expect("coll_rd_next", 4, 32'h9);

    // Out-of-range read and write.
    wr(0, 32'h0000_1234, 4'hF);
    wr(DEPTH - 1, 32'h0000_BEEF, 4'hF);
    idle(); cpu_req = 1'b1; cpu_addr = AW'(DEPTH);
    step(); idle();
    check("oor_rd_err_l1", {31'b0, err1 & rvalid1}, 32'd1);
    check("oor_rd_data_l1", rdata1, 32'h0);
    step();
    check("oor_rd_err_l2", {31'b0, err2 & rvalid2}, 32'd1);
    check("oor_rd_data_l2", rdata2, 32'h0);
    wr(DEPTH, 32'h5555_5555, 4'hF);
    check("oor_wr_l1", {30'b0, err1, rvalid1}, 32'd2);
    step();
    check("oor_wr_l2", {30'b0, err2, rvalid2}, 32'd2);
    rd_expect("oor_keep0", 0, 32'h0000_1234);
    rd_expect("oor_keepN", DEPTH - 1, 32'h0000_BEEF);

    // Reset one cycle after an accepted read: no response may appear.
    idle(); cpu_req = 1'b1; cpu_addr = 5;
    step(); idle();
    pulse_reset();
    check("rst_inflight_rvalid_l2", {31'b0, rvalid2}, 32'd0);
    sweep("sweep2");
    rd_expect("after_rst", 5, 32'h0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 700; n++) begin
      cpu_req   = ($urandom % 4) != 0;
      cpu_we    = $urandom % 2;
      cpu_be    = 4'($urandom);
      cpu_addr  = (($urandom % 16) == 0) ? AW'($urandom) : AW'($urandom % 20);
      cpu_wdata = $urandom;
      ld_we     = ($urandom % 4) == 0;
      ld_addr   = (($urandom % 3) == 0) ? cpu_addr : AW'($urandom % 20);
      ld_wdata  = $urandom;
      if (($urandom % 250) == 0) pulse_reset();
      else step();
    end
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
